gemm_seq_param: RTL and testbench
=================================

Name: gemm_seq_param

Overview:
- Parametrised successor to the single-MAC 8x8 matrix multiplier sequencer.
- Computes C = A x B for signed N x N matrices held in external synchronous-read memories (1-cycle read latency).
- Runs LANES MAC lanes in parallel, each producing one C column of the current row block.
- Writes packed results to the C memory, reports total cycle count, and raises done.

Parameters:
- N, 8, matrix dimension; power of 2, >= 2.
- DW, 8, signed element width of A and B.
- LANES, 1, parallel MAC lanes; power of 2; N % LANES == 0.
- CNTW, 16, width of clock_count.
- Derived ACCW = 2*DW + clog2(N): accumulator width, overflow-free for any inputs.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a multiply; sampled in IDLE and DONE only.
- a_addr  out  clog2(N*N)  A address; A is row-major, addr = row*N + k.
- a_rdata  in  DW  signed A element, valid 1 cycle after a_addr.
- b_addr  out  clog2(N*N/LANES)  shared address for all B banks; addr = k*(N/LANES) + cb.
- b_rdata  in  LANES*DW  bank l returns B[k][cb*LANES+l], valid 1 cycle after b_addr.
- c_we  out  1  C write strobe.
- c_addr  out  clog2(N*N/LANES)  C address; addr = row*(N/LANES) + cb.
- c_wdata  out  LANES*ACCW  lane l holds C[row][cb*LANES+l], signed.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high while in DONE.
- clock_count  out  CNTW  cycles spent outside IDLE/DONE in the last run.

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulators 0.
- IDLE, or DONE with start=1 -> ISSUE:
  - row=0, cb=0, k=0, clock_count=0.
  - done clears in the same cycle ISSUE is entered.
- ISSUE (N cycles):
  - Drive a_addr/b_addr for k = 0..N-1, incrementing k each cycle.
  - After k=N-1 -> DRAIN.
- Accumulate:
  - A registered valid flag follows issue by 1 cycle.
  - When valid: acc[l] <= (first ? 0 : acc[l]) + sext(a_rdata) * sext(b_lane[l]).
  - first marks k=0 data. All arithmetic is signed, sign-extended to ACCW.
- DRAIN (1 cycle): absorbs the final accumulation -> WRITE.
- WRITE (1 cycle):
  - c_we=1, c_addr = row*(N/LANES)+cb, c_wdata = all acc lanes.
  - Advance cb; on wrap (cb = N/LANES-1), cb=0 and row++.
  - If row=N-1 and cb=N/LANES-1 -> DONE; else -> ISSUE with k=0.
- c_we is high only in WRITE; no write outside it.
- Latency: every block takes N+2 cycles; total T = (N*N/LANES)*(N+2).
- clock_count:
  - Increments each cycle in ISSUE/DRAIN/WRITE.
  - Saturates at 2^CNTW-1.
  - Holds its value in DONE and IDLE.
- DONE: holds until start (restart) or reset. Memories are not re-read.
- start while busy is ignored.
- reset mid-operation:
  - Returns to IDLE next edge, c_we=0 immediately at that edge, counters 0.
  - No partial write occurs.
- Unused address MSBs are zero; addresses never exceed their range.

Decomposition:
- Shared package gemm_pkg:
  - state encoding (IDLE, ISSUE, DRAIN, WRITE, DONE);
  - clog2 function;
  - ACCW derivation function.
- One sub-module, gemm_mac_lane: signed DW x DW multiply-accumulate with a clear-on-first input, ACCW output. Instantiated LANES times in a generate loop.
- Address generation and the FSM stay in the top module.

Test Plan:
- N=8, LANES=1: A = identity, B[i][j] = i*8+j-32 -> C == B; 64 writes at c_addr 0..63 in order; done after 640 cycles; clock_count=640.
- N=8, LANES=1: A and B all -128 -> every C = 131072 (8*16384), no overflow in ACCW=19.
- N=8, LANES=4: random signed A/B vs. golden model -> 16 writes; each lane matches; clock_count=160.
- N=4, LANES=2, DW=4: A all 7, B all -8 -> every C = -224; clock_count=48.
- Assert reset at cycle 100 of an N=8 run -> IDLE next cycle, c_we=0, busy=0, done=0, clock_count=0; a fresh start completes correctly.
- start pulses during busy ignored; start in DONE re-runs -> identical C contents and clock_count; done low for the entire rerun.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared definitions for the parametrised GEMM sequencer: FSM state encoding
// and the compile-time width helpers used by the top and the MAC lanes.
package gemm_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Accumulator width that cannot overflow for n signed dw x dw products.
  function automatic int accw(input int dw, input int n);
    return 2 * dw + clog2(n);
  endfunction

endpackage

// File: rtl/gemm_mac_lane.sv
// One signed multiply-accumulate lane: acc = (first ? 0 : acc) + a*b when en,
// with both operands sign-extended to the accumulator width.
module gemm_mac_lane
  import gemm_pkg::*;
#(
  parameter int DW   = 8,
  parameter int ACCW = 19
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            first,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [ACCW-1:0] acc
);

  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] a_ext, b_ext;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    a_ext = ACCW'($signed(a));
    b_ext = ACCW'($signed(b));
    acc_d = acc_q;
    if (en) acc_d = (first ? '0 : acc_q) + a_ext * b_ext;
  end

  // NOTE: state updates use non-blocking assignments; the accumulator is a
  // plain register (not a memory), so it is cleared by reset like any flop.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/gemm_seq_param.sv
// Parametrised C = A x B sequencer: issues N reads per row block, accumulates
// in LANES parallel MAC lanes, writes one packed C word per block.
module gemm_seq_param
  import gemm_pkg::*;
#(
  parameter int N     = 8,
  parameter int DW    = 8,
  parameter int LANES = 1,
  parameter int CNTW  = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  output logic [clog2(N*N)-1:0]             a_addr,
  input  logic [DW-1:0]                     a_rdata,
  output logic [clog2(N*N/LANES)-1:0]       b_addr,
  input  logic [LANES*DW-1:0]               b_rdata,
  output logic                              c_we,
  output logic [clog2(N*N/LANES)-1:0]       c_addr,
  output logic [LANES*accw(DW, N)-1:0]      c_wdata,
  output logic                              busy,
  output logic                              done,
  output logic [CNTW-1:0]                   clock_count
);

  localparam int ACCW = accw(DW, N);
  localparam int KW   = clog2(N);
  localparam int NCB  = N / LANES;
  localparam int CBW  = (NCB > 1) ? clog2(NCB) : 1;
  localparam int BW   = clog2(N * N / LANES);

  logic [2:0]      state_q, state_d;
  logic [KW-1:0]   row_q, row_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CBW-1:0]  cb_q, cb_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            first_q, first_d;
  logic            last_k, last_cb, last_row;

  assign busy = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_WRITE);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    k_d      = k_q;
    cb_d     = cb_q;
    cnt_d    = cnt_q;
    last_k   = (k_q == KW'(N - 1));
    last_cb  = (cb_q == CBW'(NCB - 1));
    last_row = (row_q == KW'(N - 1));

    if (busy && (cnt_q != '1)) cnt_d = cnt_q + CNTW'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_ISSUE;
          row_d   = '0;
          cb_d    = '0;
          k_d     = '0;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        k_d = k_q + KW'(1);
        if (last_k) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: begin
        k_d = '0;
        if (last_cb) begin
          cb_d  = '0;
          row_d = row_q + KW'(1);
        end else begin
          cb_d = cb_q + CBW'(1);
        end
        state_d = (last_cb && last_row) ? S_DONE : S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase

    // Read data returns one cycle after issue; first tags the k=0 operands.
    valid_d = (state_q == S_ISSUE);
    first_d = (state_q == S_ISSUE) && (k_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      k_q     <= '0;
      cb_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      k_q     <= k_d;
      cb_q    <= cb_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      first_q <= first_d;
    end
  end

  assign a_addr      = {row_q, k_q};
  assign b_addr      = BW'(k_q) * BW'(NCB) + BW'(cb_q);
  assign c_addr      = BW'(row_q) * BW'(NCB) + BW'(cb_q);
  assign c_we        = (state_q == S_WRITE);
  assign done        = (state_q == S_DONE);
  assign clock_count = cnt_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    gemm_mac_lane #(
      .DW  (DW),
      .ACCW(ACCW)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .en   (valid_q),
      .first(first_q),
      .a    (a_rdata),
      .b    (b_rdata[l*DW +: DW]),
      .acc  (c_wdata[l*ACCW +: ACCW])
    );
  end

endmodule

// File: tb/tb_gemm_seq_param.sv
// Bench for gemm_seq_param: three configurations with behavioural memories and
// a scoreboard of expected C writes checked as the DUTs write them.
module tb_gemm_seq_param;
  import gemm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [2:0]  start = '0;
  logic [2:0]  rst   = '1;
  logic [2:0]  done_v, busy_v, cwe_v;
  logic [15:0] cc [3];

  int am [3][64];
  int bm [3][64];
  int qa0[$], qa1[$], qa2[$];
  longint qv0[$], qv1[$], qv2[$];

  // Instance 0: N=8, LANES=1, DW=8
  logic [5:0]  a_addr_a, b_addr_a, c_addr_a;
  logic [7:0]  a_rd_a, b_rd_a;
  logic [18:0] c_wd_a;
  gemm_seq_param #(.N(8), .DW(8), .LANES(1), .CNTW(16)) u_a (
    .clk(clk), .reset(rst[0]), .start(start[0]),
    .a_addr(a_addr_a), .a_rdata(a_rd_a), .b_addr(b_addr_a), .b_rdata(b_rd_a),
    .c_we(cwe_v[0]), .c_addr(c_addr_a), .c_wdata(c_wd_a),
    .busy(busy_v[0]), .done(done_v[0]), .clock_count(cc[0]));

  // Instance 1: N=8, LANES=4, DW=8
  logic [5:0]  a_addr_b;
  logic [3:0]  b_addr_b, c_addr_b;
  logic [7:0]  a_rd_b;
  logic [31:0] b_rd_b;
  logic [75:0] c_wd_b;
  gemm_seq_param #(.N(8), .DW(8), .LANES(4), .CNTW(16)) u_b (
    .clk(clk), .reset(rst[1]), .start(start[1]),
    .a_addr(a_addr_b), .a_rdata(a_rd_b), .b_addr(b_addr_b), .b_rdata(b_rd_b),
    .c_we(cwe_v[1]), .c_addr(c_addr_b), .c_wdata(c_wd_b),
    .busy(busy_v[1]), .done(done_v[1]), .clock_count(cc[1]));

  // Instance 2: N=4, LANES=2, DW=4
  logic [3:0]  a_addr_c;
  logic [2:0]  b_addr_c, c_addr_c;
  logic [3:0]  a_rd_c;
  logic [7:0]  b_rd_c;
  logic [19:0] c_wd_c;
  gemm_seq_param #(.N(4), .DW(4), .LANES(2), .CNTW(16)) u_c (
    .clk(clk), .reset(rst[2]), .start(start[2]),
    .a_addr(a_addr_c), .a_rdata(a_rd_c), .b_addr(b_addr_c), .b_rdata(b_rd_c),
    .c_we(cwe_v[2]), .c_addr(c_addr_c), .c_wdata(c_wd_c),
    .busy(busy_v[2]), .done(done_v[2]), .clock_count(cc[2]));

  // Synchronous-read memories; B bank l of address k*NCB+cb holds B[k][cb*LANES+l].
  always @(posedge clk) begin
    a_rd_a <= am[0][int'(a_addr_a)][7:0];
    b_rd_a <= bm[0][int'(b_addr_a)][7:0];
    a_rd_b <= am[1][int'(a_addr_b)][7:0];
    for (int l = 0; l < 4; l++)
      b_rd_b[l*8 +: 8] <= bm[1][(int'(b_addr_b) / 2) * 8 + (int'(b_addr_b) % 2) * 4 + l][7:0];
    a_rd_c <= am[2][int'(a_addr_c)][3:0];
    for (int l = 0; l < 2; l++)
      b_rd_c[l*4 +: 4] <= bm[2][(int'(b_addr_c) / 2) * 4 + (int'(b_addr_c) % 2) * 2 + l][3:0];
  end

  task automatic push_exp(input int id, input int addr, input longint v);
    case (id)
      0: begin qa0.push_back(addr); qv0.push_back(v); end
      1: begin qa1.push_back(addr); qv1.push_back(v); end
      default: begin qa2.push_back(addr); qv2.push_back(v); end
    endcase
  endtask

  function automatic int pending(input int id);
    case (id)
      0: return qa0.size();
      1: return qa1.size();
      default: return qa2.size();
    endcase
  endfunction

  task automatic flush(input int id);
    case (id)
      0: begin qa0.delete(); qv0.delete(); end
      1: begin qa1.delete(); qv1.delete(); end
      default: begin qa2.delete(); qv2.delete(); end
    endcase
  endtask

  // Golden matrix product, queued in write order (row, column block, lane).
  task automatic golden(input int id, input int n, input int lanes);
    longint s;
    for (int i = 0; i < n; i++)
      for (int cb = 0; cb < n / lanes; cb++)
        for (int l = 0; l < lanes; l++) begin
          s = 0;
          for (int k = 0; k < n; k++)
            s += longint'(am[id][i*n + k]) * longint'(bm[id][k*n + cb*lanes + l]);
          push_exp(id, i * (n / lanes) + cb, s);
        end
  endtask

  task automatic push_const(input int id, input int n, input int lanes, input longint v);
    for (int i = 0; i < n; i++)
      for (int cb = 0; cb < n / lanes; cb++)
        for (int l = 0; l < lanes; l++) push_exp(id, i * (n / lanes) + cb, v);
  endtask

  // Scoreboard monitors, sampled on the falling edge.
  always @(negedge clk) if (cwe_v[0]) begin
    if (qa0.size() == 0) check("a_extra_write", 1, 0);
    else begin
      check("a_c_addr", c_addr_a, qa0.pop_front());
      check("a_c_lane", $signed(c_wd_a), qv0.pop_front());
    end
  end

  always @(negedge clk) if (cwe_v[1]) begin
    for (int l = 0; l < 4; l++) begin
      if (qa1.size() == 0) check("b_extra_write", 1, 0);
      else begin
        check("b_c_addr", c_addr_b, qa1.pop_front());
        check("b_c_lane", $signed(c_wd_b[l*19 +: 19]), qv1.pop_front());
      end
    end
  end

  always @(negedge clk) if (cwe_v[2]) begin
    for (int l = 0; l < 2; l++) begin
      if (qa2.size() == 0) check("c_extra_write", 1, 0);
      else begin
        check("c_c_addr", c_addr_c, qa2.pop_front());
        check("c_c_lane", $signed(c_wd_c[l*10 +: 10]), qv2.pop_front());
      end
    end
  end

  task automatic run(input int id, input int t_exp, input string tag, input bit pulse);
    int n;
    n = 0;
    @(negedge clk) start[id] = 1'b1;
    @(negedge clk) start[id] = 1'b0;
    check({tag, "_done_cleared"}, done_v[id], 0);
    check({tag, "_busy"}, busy_v[id], 1);
    while (!done_v[id] && n < 5000) begin
      start[id] = pulse && (n % 7 == 3);
      @(negedge clk);
      n++;
    end
    start[id] = 1'b0;
    check({tag, "_cycles"}, n, t_exp);
    check({tag, "_clock_count"}, cc[id], t_exp);
    check({tag, "_pending"}, pending(id), 0);
    check({tag, "_busy_end"}, busy_v[id], 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        am[0][i*8 + j] = (i == j) ? 1 : 0;
        bm[0][i*8 + j] = i * 8 + j - 32;
        am[1][i*8 + j] = int'($urandom_range(0, 255)) - 128;
        bm[1][i*8 + j] = int'($urandom_range(0, 255)) - 128;
      end
    for (int i = 0; i < 16; i++) begin
      am[2][i] = 7;
      bm[2][i] = -8;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_c_we", cwe_v[0], 0);
    check("rst_busy", busy_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_clock_count", cc[0], 0);
    check("rst_a_addr", a_addr_a, 0);
    check("rst_c_wdata", c_wd_a, 0);
    @(negedge clk) rst = '0;

    golden(0, 8, 1);
    run(0, 640, "ident", 1'b0);

    for (int i = 0; i < 64; i++) begin
      am[0][i] = -128;
      bm[0][i] = -128;
    end
    push_const(0, 8, 1, 131072);
    run(0, 640, "neg128", 1'b0);

    golden(1, 8, 4);
    run(1, 160, "rand_l4", 1'b0);

    push_const(2, 4, 2, -224);
    run(2, 48, "const_n4", 1'b1);
    push_const(2, 4, 2, -224);
    run(2, 48, "rerun_n4", 1'b0);

    // Reset in the middle of a run, then a clean rerun.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        am[0][i*8 + j] = (i == j) ? 1 : 0;
        bm[0][i*8 + j] = i * 8 + j - 32;
      end
    golden(0, 8, 1);
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (99) @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_c_we", cwe_v[0], 0);
    check("mid_rst_busy", busy_v[0], 0);
    check("mid_rst_done", done_v[0], 0);
    check("mid_rst_clock_count", cc[0], 0);
    @(negedge clk) rst[0] = 1'b0;
    flush(0);
    golden(0, 8, 1);
    run(0, 640, "after_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
